device_b_responder: RTL and testbench

// Peer endpoint (device B) of the two-wire 4-phase handshake driven by device A's devA line.

---
 rtl/hs_pkg.sv | 22 ++
 rtl/hs_down_counter.sv | 30 +++
 rtl/device_b_responder.sv | 200 ++++++++++++++++++++
 tb/tb_device_b_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the two-wire 4-phase handshake between device A and device B.
package hs_pkg;

  // Device B handshake states; encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    B_DLY  = 3'd1,
    B_ACK  = 3'd2,
    B_REQ  = 3'd3,
    B_REL  = 3'd4,
    B_COLL = 3'd5
  } hs_b_state_t;

  // Width in cycles of every status pulse (rx_valid, tx_done, collision, timeout).
  localparam int HS_PULSE_W = 1;

  // Device B raises its line only while acknowledging an A write or requesting its own.
  function automatic logic hs_b_drives(input logic [2:0] st);
    return (st == 3'(B_ACK)) || (st == 3'(B_REQ));
  endfunction

endpackage

// File: rtl/hs_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it has reached zero.
module hs_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/device_b_responder.sv
// Device B endpoint of the devA/devB 4-phase handshake: serves A-initiated writes
// with a programmable acknowledge delay and issues its own writes with timeout
// and same-edge collision detection. All outputs are registered.
module device_b_responder
  import hs_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ACK_DLY = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             devA,
  output logic             devB,
  input  logic [DW-1:0]    a_data,
  input  logic             send,
  input  logic [DW-1:0]    data_tx,
  output logic [DW-1:0]    b_data,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  output logic             tx_done,
  output logic             collision,
  output logic             timeout,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_B_DLY  = 3'(B_DLY);
  localparam logic [2:0] ST_B_ACK  = 3'(B_ACK);
  localparam logic [2:0] ST_B_REQ  = 3'(B_REQ);
  localparam logic [2:0] ST_B_REL  = 3'(B_REL);
  localparam logic [2:0] ST_B_COLL = 3'(B_COLL);

  localparam int DLY_W = (ACK_DLY > 2) ? $clog2(ACK_DLY) : 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = (ACK_DLY > 0) ? DLY_W'(ACK_DLY - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             first_r;
  logic             devb_r;
  logic [DW-1:0]    b_data_r;
  logic [DW-1:0]    rx_data_r;
  logic             rx_valid_r;
  logic             tx_done_r;
  logic             collision_r;
  logic             timeout_r;
  logic [CNT_W-1:0] xfer_cnt_r;

  logic dly_load_s, dly_dec_s, dly_zero_s;
  logic tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic capture_s, latch_tx_s, tx_done_s, coll_s, tmo_s;

  hs_down_counter #(.W(DLY_W)) u_ack_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load_s),
    .load_val (DLY_LOAD),
    .dec      (dly_dec_s),
    .zero     (dly_zero_s)
  );

  hs_down_counter #(.W(TMR_W)) u_req_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (TMR_LOAD),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and event decode; a devA seen on the first B_REQ edge can only be A's own request.
  always_comb begin
    state_nxt_s = state_r;
    dly_load_s  = 1'b0;
    dly_dec_s   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_dec_s   = 1'b0;
    capture_s   = 1'b0;
    latch_tx_s  = 1'b0;
    tx_done_s   = 1'b0;
    coll_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (devA) begin
          if (ACK_DLY == 0) begin
            state_nxt_s = ST_B_ACK;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ST_B_DLY;
            dly_load_s  = 1'b1;
          end
        end else if (send) begin
          state_nxt_s = ST_B_REQ;
          latch_tx_s  = 1'b1;
          tmr_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_B_DLY: begin
        if (!devA) begin
          state_nxt_s = ST_IDLE;
        end else if (dly_zero_s) begin
          state_nxt_s = ST_B_ACK;
          capture_s   = 1'b1;
        end else begin
          dly_dec_s   = 1'b1;
        end
      end
      ST_B_ACK: begin
        if (!devA) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_B_ACK;
        end
      end
      ST_B_REQ: begin
        if (devA) begin
          if (first_r) begin
            state_nxt_s = ST_B_COLL;
            coll_s      = 1'b1;
          end else begin
            state_nxt_s = ST_B_REL;
            tx_done_s   = 1'b1;
          end
        end else if (tmr_zero_s) begin
          state_nxt_s = ST_B_REL;
          tmo_s       = 1'b1;
        end else begin
          tmr_dec_s   = 1'b1;
        end
      end
      ST_B_REL, ST_B_COLL: begin
        if (!devA) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, handshake line, payload and status registers; devB follows the next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      first_r     <= 1'b0;
      devb_r      <= 1'b0;
      b_data_r    <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      tx_done_r   <= 1'b0;
      collision_r <= 1'b0;
      timeout_r   <= 1'b0;
      xfer_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      first_r     <= latch_tx_s;
      devb_r      <= hs_b_drives(state_nxt_s);
      if (latch_tx_s) begin
        b_data_r <= data_tx;
      end else if (state_nxt_s == ST_B_REQ) begin
        b_data_r <= b_data_r;
      end else begin
        b_data_r <= '0;
      end
      if (capture_s) begin
        rx_data_r <= a_data;
      end else begin
        rx_data_r <= rx_data_r;
      end
      rx_valid_r  <= capture_s;
      tx_done_r   <= tx_done_s;
      collision_r <= coll_s;
      timeout_r   <= tmo_s;
      if (capture_s || tx_done_s) begin
        xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
      end else begin
        xfer_cnt_r <= xfer_cnt_r;
      end
    end
  end

  assign devB      = devb_r;
  assign b_data    = b_data_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign tx_done   = tx_done_r;
  assign collision = collision_r;
  assign timeout   = timeout_r;
  assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_device_b_responder.sv
// Self-checking bench for device_b_responder: acts as device A, drives table
// vectors, hand-written corner sequences and random transactions, and compares
// against a transaction-level model (latencies, last received data, transfer count).
module tb_device_b_responder;

  localparam int ACK_DLY = 2;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic       devA;
  logic       devB;
  logic [7:0] a_data;
  logic       send;
  logic [7:0] data_tx;
  logic [7:0] b_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       collision;
  logic       timeout;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [7:0] model_rx = 8'h00;

  // kind: 0 = A write, 1 = A write aborted in the delay phase, 2 = B write echoed by A
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         param;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  device_b_responder #(.DW(8), .ACK_DLY(ACK_DLY), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .devA      (devA),
    .devB      (devB),
    .a_data    (a_data),
    .send      (send),
    .data_tx   (data_tx),
    .b_data    (b_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_done   (tx_done),
    .collision (collision),
    .timeout   (timeout),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] d, input bit abort, input int exp_lat);
    int lat;
    int rv;
    lat = 0;
    rv = 0;
    devA = 1'b1;
    a_data = d;
    if (abort) begin
      tick();
      rv += int'(rx_valid);
      lat += int'(devB);
      devA = 1'b0;
      repeat (3) begin
        tick();
        rv += int'(rx_valid);
        lat += int'(devB);
      end
      chk("abort_devb", 32'(lat), 32'd0);
      chk("abort_rxvalid", 32'(rv), 32'd0);
      chk("abort_rxdata", 32'(rx_data), 32'(model_rx));
      chk("abort_cnt", 32'(xfer_cnt), 32'(model_cnt & 255));
    end else begin
      while (devB !== 1'b1 && lat < 20) begin
        tick();
        lat++;
        rv += int'(rx_valid);
      end
      chk("a_latency", 32'(lat), 32'(exp_lat));
      chk("a_rxvalid_count", 32'(rv), 32'd1);
      chk("a_rxvalid_at_ack", 32'(rx_valid), 32'd1);
      chk("a_rxdata", 32'(rx_data), 32'(d));
      chk("a_bdata_zero", 32'(b_data), 32'd0);
      model_rx = d;
      model_cnt++;
      chk("a_cnt", 32'(xfer_cnt), 32'(model_cnt & 255));
      tick();
      chk("a_rxvalid_1cyc", 32'(rx_valid), 32'd0);
      chk("a_ack_hold", 32'(devB), 32'd1);
      devA = 1'b0;
      tick();
      chk("a_release", 32'(devB), 32'd0);
    end
  endtask

  task automatic b_write(input logic [7:0] d, input int echo, input int exp_lat);
    int lat;
    int n;
    int td;
    lat = 0;
    td = 0;
    send = 1'b1;
    data_tx = d;
    while (devB !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("b_latency", 32'(lat), 32'(exp_lat));
    chk("b_data", 32'(b_data), 32'(d));
    data_tx = ~d;
    repeat (echo) begin
      tick();
      td += int'(tx_done);
    end
    chk("b_no_early_done", 32'(td), 32'd0);
    chk("b_data_hold", 32'(b_data), 32'(d));
    chk("b_devb_hold", 32'(devB), 32'd1);
    devA = 1'b1;
    n = 0;
    while (tx_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("b_done_latency", 32'(n), 32'd1);
    send = 1'b0;
    chk("b_devb_drop", 32'(devB), 32'd0);
    chk("b_data_clear", 32'(b_data), 32'd0);
    model_cnt++;
    chk("b_cnt", 32'(xfer_cnt), 32'(model_cnt & 255));
    tick();
    chk("b_done_1cyc", 32'(tx_done), 32'd0);
    chk("b_rel_low", 32'(devB), 32'd0);
    devA = 1'b0;
    tick();
    tick();
    chk("b_idle", 32'(devB), 32'd0);
  endtask

  initial begin
    int n;
    int td;
    int r;

    reset = 1'b0;
    devA = 1'b0;
    send = 1'b0;
    a_data = 8'h00;
    data_tx = 8'h00;

    vecs[0] = '{0, 8'hA5, 0, ACK_DLY + 1};
    vecs[1] = '{2, 8'h3C, 1, 1};
    vecs[2] = '{1, 8'h99, 0, 0};
    vecs[3] = '{0, 8'h00, 0, ACK_DLY + 1};
    vecs[4] = '{2, 8'hFF, 4, 1};
    vecs[5] = '{0, 8'h5A, 0, ACK_DLY + 1};

    // Reset state
    #12;
    chk("rst_devb", 32'(devB), 32'd0);
    chk("rst_bdata", 32'(b_data), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'd0);
    chk("rst_pulses", 32'({rx_valid, tx_done, collision, timeout}), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    #4;
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_devb", 32'(devB), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      case (vecs[i].kind)
        0:       a_write(vecs[i].data, 1'b0, vecs[i].exp_lat);
        1:       a_write(vecs[i].data, 1'b1, vecs[i].exp_lat);
        default: b_write(vecs[i].data, vecs[i].param, vecs[i].exp_lat);
      endcase
    end

    // devA and send together in IDLE: A write first, then the B write
    send = 1'b1;
    data_tx = 8'h6E;
    a_write(8'h42, 1'b0, ACK_DLY + 1);
    b_write(8'h6E, 2, 1);

    // Collision: A raises devA on the same edge B raises devB
    send = 1'b1;
    data_tx = 8'h77;
    tick();
    chk("coll_req_devb", 32'(devB), 32'd1);
    devA = 1'b1;
    a_data = 8'h11;
    tick();
    chk("coll_pulse", 32'(collision), 32'd1);
    chk("coll_devb", 32'(devB), 32'd0);
    chk("coll_no_done", 32'(tx_done), 32'd0);
    chk("coll_cnt", 32'(xfer_cnt), 32'(model_cnt & 255));
    devA = 1'b0;
    tick();
    chk("coll_1cyc", 32'(collision), 32'd0);
    chk("coll_devb_low", 32'(devB), 32'd0);
    b_write(8'h77, 1, 1);

    // Timeout: A stays silent
    send = 1'b1;
    data_tx = 8'h5A;
    n = 0;
    while (devB !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("tmo_req_latency", 32'(n), 32'd1);
    n = 0;
    td = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
      td += int'(tx_done);
    end
    chk("tmo_latency", 32'(n), 32'(TIMEOUT));
    chk("tmo_devb", 32'(devB), 32'd0);
    chk("tmo_bdata", 32'(b_data), 32'd0);
    chk("tmo_no_done", 32'(td), 32'd0);
    send = 1'b0;
    tick();
    chk("tmo_1cyc", 32'(timeout), 32'd0);
    tick();
    chk("tmo_idle_devb", 32'(devB), 32'd0);
    chk("tmo_cnt", 32'(xfer_cnt), 32'(model_cnt & 255));

    // Asynchronous reset while B_REQ is driving devB
    send = 1'b1;
    data_tx = 8'hC3;
    tick();
    chk("rreq_devb", 32'(devB), 32'd1);
    chk("rreq_bdata", 32'(b_data), 32'hC3);
    #2;
    reset = 1'b0;
    #1;
    chk("rreq_async_devb", 32'(devB), 32'd0);
    chk("rreq_async_bdata", 32'(b_data), 32'd0);
    chk("rreq_async_cnt", 32'(xfer_cnt), 32'd0);
    chk("rreq_async_rxdata", 32'(rx_data), 32'd0);
    send = 1'b0;
    model_cnt = 0;
    model_rx = 8'h00;
    #2;
    reset = 1'b1;
    tick();
    tick();
    chk("rreq_after_devb", 32'(devB), 32'd0);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      case (r)
        0:       a_write(8'($urandom), 1'b0, ACK_DLY + 1);
        1:       a_write(8'($urandom), 1'b1, 0);
        default: b_write(8'($urandom), $urandom_range(1, 4), 1);
      endcase
    end

    // Counter wrap
    while (!(model_cnt >= 256 && (model_cnt & 255) == 0)) begin
      a_write(8'($urandom), 1'b0, ACK_DLY + 1);
    end
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
